// File: rtl/bvinv_pkg.sv
// bvinv_pkg: shared FSM states, mode encodings and closed-form invertibility checks
package bvinv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, DIV, CHECK, RESP} state_e;
  localparam logic MODE_XUREMS = 1'b0;
  localparam logic MODE_SUREMX = 1'b1;
  // (x urem s) >u t has a witness iff t is below the largest reachable remainder.
  // That remainder is s-1, or all-ones when s=0. Both equal ~(-s) = s-1 truncated to w bits.
  function automatic logic xurems_invertible(logic [15:0] s, logic [15:0] t, int w);
    logic [15:0] m;
    m = 16'((32'd1 << w) - 32'd1);
    return t < ((s - 16'd1) & m);
  endfunction
  // (s urem x) >u t has a witness iff t <u s, and then x=0 is one because s urem 0 = s
  function automatic logic surems_invertible(logic [15:0] s, logic [15:0] t);
    return t < s;
  endfunction
endpackage

// File: rtl/bvinv_serial_urem.sv
// bvinv_serial_urem: restoring serial unsigned remainder, one quotient bit per cycle
//   start    : load dividend/divisor (one-cycle pulse)
//   done     : the final step completes on this rising edge; rem is valid afterwards
//   rem      : remainder, equal to the dividend when the divisor is 0
module bvinv_serial_urem #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] rem
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] q, d;
  logic [CW-1:0] cnt;
  logic [W:0] rs;
  logic ge;
  // A zero divisor always passes the compare and subtracts nothing, so the dividend
  // bits shift straight into rem and give the required a urem 0 = a.
  always_comb begin
    rs = {rem, q[W-1]};
    ge = rs >= {1'b0, d};
  end
  assign done = cnt == CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      q   <= dividend;
      d   <= divisor;
      cnt <= CW'(W);
    end else if (cnt != '0) begin
      rem <= ge ? rs[W-1:0] - d : rs[W-1:0];
      q   <= {q[W-2:0], ge};
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/bvurem_ugt_inv_solver.sv
// bvurem_ugt_inv_solver: finds the smallest x with (x urem s) >u t or (s urem x) >u t
//   req_valid/req_ready : request handshake, req_mode selects the constraint, req_s/req_t operands
//   rsp_valid/rsp_ready : response handshake, rsp_sat witness found, rsp_x witness (0 if unsat)
//   busy                : high whenever the FSM is out of IDLE
//   BVINV_FASTPATH_EN   : when defined, closed-form cases answer one cycle after acceptance
module bvurem_ugt_inv_solver #(parameter int W = 4) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_mode,
  input  logic [W-1:0] req_s,
  input  logic [W-1:0] req_t,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_sat,
  output logic [W-1:0] rsp_x,
  output logic         busy
);
  import bvinv_pkg::*;
  state_e state;
  logic mode, fast, fast_sat, done;
  logic [W-1:0] s, t, x, rem;
  bvinv_serial_urem #(.W(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (state == LOAD),
    .dividend (mode == MODE_SUREMX ? s : x),
    .divisor  (mode == MODE_SUREMX ? x : s),
    .done     (done),
    .rem      (rem)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      mode      <= MODE_XUREMS;
      s         <= '0;
      t         <= '0;
      x         <= '0;
      fast      <= 1'b0;
      fast_sat  <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sat   <= 1'b0;
      rsp_x     <= '0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            mode      <= req_mode;
            s         <= req_s;
            t         <= req_t;
            x         <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
`ifdef BVINV_FASTPATH_EN
            fast      <= req_mode == MODE_SUREMX || !xurems_invertible(16'(req_s), 16'(req_t), W);
            fast_sat  <= req_mode == MODE_SUREMX && surems_invertible(16'(req_s), 16'(req_t));
`else
            fast      <= 1'b0;
            fast_sat  <= 1'b0;
`endif
          end
        LOAD:
          if (fast) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_sat   <= fast_sat;
            rsp_x     <= '0;
          end else
            state <= DIV;
        DIV:
          if (done) state <= CHECK;
        CHECK:
          if (rem > t) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_sat   <= 1'b1;
            rsp_x     <= x;
          end else if (&x) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_sat   <= 1'b0;
            rsp_x     <= '0;
          end else begin
            x     <= x + W'(1);
            state <= LOAD;
          end
        RESP:
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_sat   <= 1'b0;
            rsp_x     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule
